// File: rtl/monopix_flavor_readout.sv
// TJ-Monopix front-end flavour model: pixel hit capture with 6-bit LE/TE timestamps,
// token-based column-drain readout and a 28-bit MSB-first serial data output.
module monopix_flavor_readout #(
  parameter int NCOL = 4,
  parameter int NROW = 8
) (
  input  logic                 CLK_BX_PAD,
  input  logic                 RST_N_PAD,
  input  logic                 RESET_BCID_PAD,
  input  logic [NCOL*NROW-1:0] ANA_HIT,
  input  logic [NCOL*NROW-1:0] PIX_EN,
  input  logic [NCOL*NROW-1:0] INJ_EN,
  input  logic                 PULSE_PAD,
  input  logic                 FREEZE_PAD,
  input  logic                 READ_PAD,
  output logic                 TOKEN_PAD,
  output logic                 OUT_PAD
);

  localparam int NPIX = NCOL * NROW;

  typedef enum logic [1:0] {
    PIX_IDLE = 2'd0,
    PIX_HIGH = 2'd1,
    PIX_DONE = 2'd2
  } pix_state_t;

  pix_state_t      r_state [NPIX];
  logic [5:0]      r_le    [NPIX];
  logic [5:0]      r_te    [NPIX];
  logic [5:0]      r_bcid;
  logic [NPIX-1:0] r_hit;
  logic [NPIX-1:0] r_hit_d;
  logic            r_read;
  logic            r_read_d;
  logic [27:0]     r_shift;
  logic [4:0]      r_cnt;
  logic            r_busy;
  logic            r_out;
  logic            r_token;

  logic [NPIX-1:0] w_hit;
  logic [NPIX-1:0] w_rise;
  logic [NPIX-1:0] w_fall;
  logic [NPIX-1:0] w_done;
  logic [NPIX-1:0] w_sel_onehot;
  logic            w_sel_valid;
  logic [27:0]     w_sel_word;
  logic            w_load;

  assign w_hit  = PIX_EN & (ANA_HIT | ({NPIX{PULSE_PAD}} & INJ_EN));
  assign w_rise = r_hit & ~r_hit_d;
  assign w_fall = ~r_hit & r_hit_d;
  assign w_load = r_read & ~r_read_d & FREEZE_PAD & ~r_busy & w_sel_valid;

  assign TOKEN_PAD = r_token;
  assign OUT_PAD   = r_out;

  // Column drain priority: the lowest flat index c*NROW+r holding a finished hit wins.
  always_comb begin
    w_done       = '0;
    w_sel_onehot = '0;
    w_sel_valid  = 1'b0;
    w_sel_word   = 28'd0;
    for (int i = 0; i < NPIX; i++) begin
      w_done[i] = (r_state[i] == PIX_DONE);
      if (w_done[i] && !w_sel_valid) begin
        w_sel_valid     = 1'b1;
        w_sel_onehot[i] = 1'b1;
        w_sel_word      = {7'(i / NROW), 9'(i % NROW), r_le[i], r_te[i]};
      end else begin
      end
    end
  end

  always_ff @(posedge CLK_BX_PAD or negedge RST_N_PAD) begin
    if (!RST_N_PAD) begin
      r_bcid   <= 6'd0;
      r_hit    <= '0;
      r_hit_d  <= '0;
      r_read   <= 1'b0;
      r_read_d <= 1'b0;
      r_token  <= 1'b0;
    end else begin
      r_bcid   <= RESET_BCID_PAD ? 6'd0 : r_bcid + 6'd1;
      r_hit    <= w_hit;
      r_hit_d  <= r_hit;
      r_read   <= READ_PAD;
      r_read_d <= r_read;
      r_token  <= |w_done;
    end
  end

  // A selected pixel returns to IDLE on the load edge, overriding any edge seen that cycle.
  always_ff @(posedge CLK_BX_PAD or negedge RST_N_PAD) begin
    if (!RST_N_PAD) begin
      for (int i = 0; i < NPIX; i++) begin
        r_state[i] <= PIX_IDLE;
        r_le[i]    <= 6'd0;
        r_te[i]    <= 6'd0;
      end
    end else begin
      for (int i = 0; i < NPIX; i++) begin
        if (w_load && w_sel_onehot[i]) begin
          r_state[i] <= PIX_IDLE;
        end else begin
          case (r_state[i])
            PIX_IDLE: begin
              if (w_rise[i] && !FREEZE_PAD) begin
                r_state[i] <= PIX_HIGH;
                r_le[i]    <= r_bcid;
              end
            end
            PIX_HIGH: begin
              if (w_fall[i]) begin
                r_state[i] <= PIX_DONE;
                r_te[i]    <= r_bcid;
              end
            end
            PIX_DONE: r_state[i] <= PIX_DONE;
            default:  r_state[i] <= PIX_IDLE;
          endcase
        end
      end
    end
  end

  // Shifter stays busy one extra cycle after bit 0 so OUT returns to 0 before the next load.
  always_ff @(posedge CLK_BX_PAD or negedge RST_N_PAD) begin
    if (!RST_N_PAD) begin
      r_shift <= 28'd0;
      r_cnt   <= 5'd0;
      r_busy  <= 1'b0;
      r_out   <= 1'b0;
    end else if (w_load) begin
      r_shift <= w_sel_word;
      r_cnt   <= 5'd0;
      r_busy  <= 1'b1;
      r_out   <= 1'b0;
    end else if (r_busy) begin
      if (r_cnt == 5'd28) begin
        r_busy <= 1'b0;
        r_out  <= 1'b0;
      end else begin
        r_out   <= r_shift[27];
        r_shift <= {r_shift[26:0], 1'b0};
        r_cnt   <= r_cnt + 5'd1;
      end
    end else begin
      r_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_monopix_flavor_readout.sv
// Bench for monopix_flavor_readout: directed vector table, reset-abort sequence and
// randomized traffic checked each cycle against a queue-based behavioural model.
module tb_monopix_flavor_readout;

  localparam int NCOL = 4;
  localparam int NROW = 8;
  localparam int NPIX = NCOL * NROW;

  logic            clk;
  logic            rst_n;
  logic            rst_bcid;
  logic [NPIX-1:0] ana;
  logic [NPIX-1:0] pix_en;
  logic [NPIX-1:0] inj_en;
  logic            pulse;
  logic            freeze;
  logic            read;
  logic            token;
  logic            out;

  int checks;
  int failures;

  monopix_flavor_readout #(.NCOL(NCOL), .NROW(NROW)) dut (
    .CLK_BX_PAD     (clk),
    .RST_N_PAD      (rst_n),
    .RESET_BCID_PAD (rst_bcid),
    .ANA_HIT        (ana),
    .PIX_EN         (pix_en),
    .INJ_EN         (inj_en),
    .PULSE_PAD      (pulse),
    .FREEZE_PAD     (freeze),
    .READ_PAD       (read),
    .TOKEN_PAD      (token),
    .OUT_PAD        (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: phase 0 = idle, 1 = hit open, 2 = hit closed awaiting readout.
  int              m_phase [NPIX];
  int              m_le    [NPIX];
  int              m_te    [NPIX];
  int              m_bcid;
  logic [NPIX-1:0] m_h;
  logic [NPIX-1:0] m_hp;
  bit              m_rd;
  bit              m_rdp;
  bit              m_q [$];
  bit              m_token;
  bit              m_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NPIX; i++) begin
      m_phase[i] = 0;
      m_le[i]    = 0;
      m_te[i]    = 0;
    end
    m_bcid  = 0;
    m_h     = '0;
    m_hp    = '0;
    m_rd    = 1'b0;
    m_rdp   = 1'b0;
    m_q.delete();
    m_token = 1'b0;
    m_out   = 1'b0;
  endtask

  task automatic model_step();
    bit          busy;
    int          sel;
    logic [27:0] w;
    busy    = (m_q.size() != 0);
    m_token = 1'b0;
    for (int i = 0; i < NPIX; i++) if (m_phase[i] == 2) m_token = 1'b1;
    m_out = busy ? m_q.pop_front() : 1'b0;
    sel = -1;
    if (m_rd && !m_rdp && freeze && !busy)
      for (int i = 0; i < NPIX; i++) if (sel < 0 && m_phase[i] == 2) sel = i;
    for (int i = 0; i < NPIX; i++) begin
      if (i == sel) begin
        w = {7'(i / NROW), 9'(i % NROW), 6'(m_le[i]), 6'(m_te[i])};
        m_phase[i] = 0;
        for (int b = 27; b >= 0; b--) m_q.push_back(w[b]);
        m_q.push_back(1'b0);
      end else if (m_phase[i] == 0 && m_h[i] && !m_hp[i] && !freeze) begin
        m_phase[i] = 1;
        m_le[i]    = m_bcid;
      end else if (m_phase[i] == 1 && !m_h[i] && m_hp[i]) begin
        m_phase[i] = 2;
        m_te[i]    = m_bcid;
      end
    end
    m_bcid = rst_bcid ? 0 : (m_bcid + 1) % 64;
    m_hp   = m_h;
    m_h    = pix_en & (ana | ({NPIX{pulse}} & inj_en));
    m_rdp  = m_rd;
    m_rd   = read;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("out_model", {31'd0, out}, {31'd0, m_out});
    chk("token_model", {31'd0, token}, {31'd0, m_token});
  endtask

  task automatic read_word(input string name, input logic [27:0] exp);
    logic [27:0] w;
    w = 28'd0;
    read = 1'b1;
    tick();
    tick();
    for (int b = 0; b < 28; b++) begin
      tick();
      w = {w[26:0], out};
    end
    read = 1'b0;
    tick();
    tick();
    tick();
    chk(name, {4'd0, w}, {4'd0, exp});
  endtask

  typedef struct {
    string           name;
    logic [NPIX-1:0] ana;
    logic [NPIX-1:0] pix_en;
    logic [NPIX-1:0] inj_en;
    bit              pulse;
    bit              freeze_early;
    int              start;
    int              len;
    int              nwords;
    logic [27:0]     w0;
    logic [27:0]     w1;
  } vec_t;

  vec_t vecs [5];

  task automatic run_vec(input vec_t v);
    freeze   = 1'b0;
    read     = 1'b0;
    ana      = '0;
    pulse    = 1'b0;
    pix_en   = v.pix_en;
    inj_en   = v.inj_en;
    repeat (3) tick();
    freeze   = v.freeze_early;
    rst_bcid = 1'b1;
    tick();
    rst_bcid = 1'b0;
    repeat (v.start - 1) tick();
    ana   = v.ana;
    pulse = v.pulse;
    repeat (v.len) tick();
    ana   = '0;
    pulse = 1'b0;
    repeat (4) tick();
    freeze = 1'b1;
    tick();
    read_word({v.name, "_w0"}, (v.nwords > 0) ? v.w0 : 28'd0);
    read_word({v.name, "_w1"}, (v.nwords > 1) ? v.w1 : 28'd0);
    chk({v.name, "_token_end"}, {31'd0, token}, 32'd0);
    freeze = 1'b0;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    rst_bcid = 1'b0;
    ana      = '0;
    pix_en   = '1;
    inj_en   = '0;
    pulse    = 1'b0;
    freeze   = 1'b0;
    read     = 1'b0;
    model_reset();

    vecs[0] = '{"pix_1_2", 32'h0000_0400, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 5, 10, 1,
                {7'd1, 9'd2, 6'd5, 6'd15}, 28'd0};
    vecs[1] = '{"pix_3_9", 32'h0000_0208, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 20, 3, 2,
                {7'd0, 9'd3, 6'd20, 6'd23}, {7'd1, 9'd1, 6'd20, 6'd23}};
    vecs[2] = '{"inject", 32'h0000_0000, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 2, 4, 1,
                {7'd0, 9'd0, 6'd2, 6'd6}, 28'd0};
    vecs[3] = '{"frozen", 32'h0000_0020, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 3, 4, 0,
                28'd0, 28'd0};
    vecs[4] = '{"wrap_en", 32'h0010_0080, 32'hFFFF_FF7F, 32'h0, 1'b0, 1'b0, 62, 5, 1,
                {7'd2, 9'd4, 6'd62, 6'd3}, 28'd0};

    repeat (3) @(negedge clk);
    chk("reset_out", {31'd0, out}, 32'd0);
    chk("reset_token", {31'd0, token}, 32'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 5; k++) run_vec(vecs[k]);

    // Reset during shift: hits on pixels 1 and 2, abort after 10 bits of the first word.
    freeze   = 1'b0;
    rst_bcid = 1'b1;
    tick();
    rst_bcid = 1'b0;
    ana = 32'h0000_0006;
    repeat (3) tick();
    ana = '0;
    repeat (4) tick();
    freeze = 1'b1;
    read   = 1'b1;
    repeat (12) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("abort_out", {31'd0, out}, 32'd0);
    chk("abort_token", {31'd0, token}, 32'd0);
    read   = 1'b0;
    freeze = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    ana = 32'h0000_0001;
    repeat (4) tick();
    ana = '0;
    repeat (4) tick();
    freeze = 1'b1;
    tick();
    read_word("post_reset_w0", {7'd0, 9'd0, 6'd4, 6'd8});
    read_word("post_reset_w1", 28'd0);

    // Randomized traffic against the model.
    freeze = 1'b0;
    pix_en = $urandom() | $urandom();
    inj_en = $urandom() & $urandom();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NPIX; i++)
        if ($urandom_range(0, 15) == 0) ana[i] = ~ana[i];
      if ($urandom_range(0, 31) == 0) pulse = ~pulse;
      if ($urandom_range(0, 19) == 0) freeze = ~freeze;
      if ($urandom_range(0, 3) == 0) read = ~read;
      rst_bcid = ($urandom_range(0, 63) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
